sa_ram_rwsthp_param: RTL and testbench



---
 rtl/sa_ram_pkg.sv | 31 +++
 rtl/sa_ram_clr_seq.sv | 49 ++++
 rtl/sa_ram_rwsthp_param.sv | 133 +++++++++++++
 tb/tb_sa_ram_rwsthp_param.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/sa_ram_pkg.sv
// Shared types and helpers for the parametrised two-port RAM model.
package sa_ram_pkg;

  typedef enum logic {
    CLR_ST = 1'b0,
    RDY_ST = 1'b1
  } clr_state_e;

  // Widest word the bit-enable helper can expand into.
  localparam int unsigned MAX_W = 256;

  // Segment width covered by one write-mask bit; the top segment may be narrower.
  function automatic int unsigned seg_width(input int unsigned width, input int unsigned mask_w);
    return (width + mask_w - 1) / mask_w;
  endfunction

  // Expand a per-segment write mask into a per-bit enable (low `width` bits valid).
  function automatic logic [MAX_W-1:0] seg_expand(input logic [MAX_W-1:0] mask,
                                                  input int unsigned   mask_w,
                                                  input int unsigned   width);
    logic [MAX_W-1:0] en;
    int unsigned      seg;
    en  = '0;
    seg = seg_width(width, mask_w);
    for (int unsigned b = 0; b < MAX_W; b++) begin
      if (b < width) en[8'(b)] = mask[8'(b / seg)];
    end
    return en;
  endfunction

endpackage

// File: rtl/sa_ram_clr_seq.sv
// Reset-time clear sequencer: walks every address writing zero, then reports ready.
module sa_ram_clr_seq
  import sa_ram_pkg::*;
#(
  parameter int unsigned DEPTH        = 80,
  parameter int unsigned AW           = 7,
  parameter int unsigned WIDTH        = 17,
  parameter int unsigned CLR_ON_RESET = 1
) (
  input  logic             clk,
  input  logic             rstn,
  output logic             clr_we,
  output logic [AW-1:0]    clr_addr,
  output logic [WIDTH-1:0] clr_data,
  output logic             init_done
);

  localparam clr_state_e RST_ST = clr_state_e'((CLR_ON_RESET != 0) ? CLR_ST : RDY_ST);

  clr_state_e    state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;

  // Advance the clear pointer; leave CLEAR after the last word has been written.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    if (state_q == CLR_ST) begin
      ptr_d = ptr_q + AW'(1);
      if (ptr_q == AW'(DEPTH - 1)) state_d = RDY_ST;
    end
  end

  // State and pointer registers; reset restarts the clear from address 0.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= RST_ST;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  assign clr_we    = (state_q == CLR_ST);
  assign clr_addr  = ptr_q;
  assign clr_data  = '0;
  assign init_done = (state_q == RDY_ST);

endmodule

// File: rtl/sa_ram_rwsthp_param.sv
// Parametrised 1R/1W flop-array RAM: masked writes, two-stage read with
// write forwarding and bypass, output-valid flag and reset-time clear.
module sa_ram_rwsthp_param
  import sa_ram_pkg::*;
#(
  parameter int unsigned DEPTH        = 80,
  parameter int unsigned WIDTH        = 17,
  parameter int unsigned AW           = $clog2(DEPTH),
  parameter int unsigned MASK_W       = 1,
  parameter int unsigned CLR_ON_RESET = 1,
  parameter int unsigned FWD_EN       = 1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [AW-1:0]     ra,
  input  logic              re,
  input  logic              ore,
  output logic [WIDTH-1:0]  dout,
  output logic              dout_vld,
  input  logic [AW-1:0]     wa,
  input  logic              we,
  input  logic [MASK_W-1:0] wmask,
  input  logic [WIDTH-1:0]  di,
  input  logic              byp_sel,
  input  logic [WIDTH-1:0]  dbyp,
  output logic              init_done,
  input  logic [31:0]       pwrbus_ram_pd
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  logic             clr_we;
  logic [AW-1:0]    clr_addr;
  logic [WIDTH-1:0] clr_data;

  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [WIDTH-1:0] wr_data, wr_bits, wbits;

  logic [AW-1:0]    ra_q, ra_d;
  logic             re_q, re_d;
  logic [WIDTH-1:0] arr, mux;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             vld_q, vld_d;

  // Power bus is accepted for interface compatibility only.
  logic unused_pwr;
  assign unused_pwr = ^pwrbus_ram_pd;

  sa_ram_clr_seq #(
    .DEPTH        (DEPTH),
    .AW           (AW),
    .WIDTH        (WIDTH),
    .CLR_ON_RESET (CLR_ON_RESET)
  ) u_clr_seq (
    .clk       (clk),
    .rstn      (rstn),
    .clr_we    (clr_we),
    .clr_addr  (clr_addr),
    .clr_data  (clr_data),
    .init_done (init_done)
  );

  assign wbits = WIDTH'(seg_expand(MAX_W'(wmask), MASK_W, WIDTH));

  // Array write port: clear sequencer owns it during CLEAR, user writes afterwards.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = clr_addr;
    wr_data = clr_data;
    wr_bits = '1;
    if (clr_we) begin
      wr_en = 1'b1;
    end else if (we && (32'(wa) < DEPTH)) begin
      wr_en   = 1'b1;
      wr_addr = wa;
      wr_data = di;
      wr_bits = wbits;
    end
  end

  // Storage array (not reset), bit-masked read-modify-write.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= (mem_q[wr_addr] & ~wr_bits) | (wr_data & wr_bits);
  end

  // Read stage 1: capture the address while ready and re is set.
  always_comb begin
    ra_d = ra_q;
    re_d = 1'b0;
    if (init_done && re) begin
      ra_d = ra;
      re_d = 1'b1;
    end
  end

  // Read stage 2 data: array word, with same-cycle write merged in when enabled.
  always_comb begin
    arr = '0;
    if (32'(ra_q) < DEPTH) arr = mem_q[ra_q];
    if ((FWD_EN != 0) && we && (wa == ra_q)) arr = (arr & ~wbits) | (di & wbits);
    mux = byp_sel ? dbyp : arr;
  end

  // Output register next-state, gated by ore and ignored during CLEAR.
  always_comb begin
    dout_d = dout_q;
    vld_d  = vld_q;
    if (init_done && ore) begin
      dout_d = mux;
      vld_d  = re_q | byp_sel;
    end
  end

  // Read pipeline and output registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ra_q   <= '0;
      re_q   <= 1'b0;
      dout_q <= '0;
      vld_q  <= 1'b0;
    end else begin
      ra_q   <= ra_d;
      re_q   <= re_d;
      dout_q <= dout_d;
      vld_q  <= vld_d;
    end
  end

  assign dout     = dout_q;
  assign dout_vld = vld_q;

endmodule

// File: tb/tb_sa_ram_rwsthp_param.sv
// Scoreboard bench: two RAM instances (forwarding on/off) share stimulus;
// a reference model pushes expected register state each cycle, a monitor pops and compares.
module tb_sa_ram_rwsthp_param;

  localparam int DEPTH  = 80;
  localparam int WIDTH  = 17;
  localparam int AW     = 7;
  localparam int MASK_W = 3;
  localparam int SEG    = 6;

  logic              clk  = 1'b0;
  logic              rstn = 1'b0;
  logic [AW-1:0]     ra = '0, wa = '0;
  logic              re = 1'b0, ore = 1'b0, we = 1'b0, byp_sel = 1'b0;
  logic [MASK_W-1:0] wmask = '0;
  logic [WIDTH-1:0]  di = '0, dbyp = '0;
  logic [31:0]       pwr = '0;

  logic [WIDTH-1:0]  dout_a, dout_b;
  logic              vld_a, vld_b, init_a, init_b;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  sa_ram_rwsthp_param #(
    .DEPTH(DEPTH), .WIDTH(WIDTH), .MASK_W(MASK_W), .CLR_ON_RESET(1), .FWD_EN(1)
  ) u_fwd (
    .clk(clk), .rstn(rstn), .ra(ra), .re(re), .ore(ore), .dout(dout_a), .dout_vld(vld_a),
    .wa(wa), .we(we), .wmask(wmask), .di(di), .byp_sel(byp_sel), .dbyp(dbyp),
    .init_done(init_a), .pwrbus_ram_pd(pwr)
  );

  sa_ram_rwsthp_param #(
    .DEPTH(DEPTH), .WIDTH(WIDTH), .MASK_W(MASK_W), .CLR_ON_RESET(1), .FWD_EN(0)
  ) u_nofwd (
    .clk(clk), .rstn(rstn), .ra(ra), .re(re), .ore(ore), .dout(dout_b), .dout_vld(vld_b),
    .wa(wa), .we(we), .wmask(wmask), .di(di), .byp_sel(byp_sel), .dbyp(dbyp),
    .init_done(init_b), .pwrbus_ram_pd(pwr)
  );

  typedef struct {
    logic [WIDTH-1:0] da;
    logic [WIDTH-1:0] db;
    logic             vld;
    logic             init;
  } exp_t;

  exp_t exp_q[$];

  // Reference model state
  logic [WIDTH-1:0] m_mem [DEPTH];
  int               m_clr = 0;
  logic [AW-1:0]    m_ra = '0;
  logic             m_re = 1'b0;
  logic [WIDTH-1:0] m_da = '0, m_db = '0;
  logic             m_vld = 1'b0;

  function automatic logic [WIDTH-1:0] merge(input logic [WIDTH-1:0] old_v,
                                             input logic [WIDTH-1:0] new_v,
                                             input logic [MASK_W-1:0] msk);
    logic [WIDTH-1:0] bm;
    bm = '0;
    for (int b = 0; b < WIDTH; b++)
      if (((msk >> (b / SEG)) & 3'b001) != 3'b000) bm = bm | (17'd1 << b);
    return (old_v & ~bm) | (new_v & bm);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_step;
    logic [WIDTH-1:0] arr_old, arr_new;
    exp_t e;
    if (!rstn) begin
      m_clr = 0; m_ra = '0; m_re = 1'b0; m_da = '0; m_db = '0; m_vld = 1'b0;
      return;
    end
    if (m_clr < DEPTH) begin
      m_clr++;
      if (m_clr == DEPTH) for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
    end else begin
      arr_old = (int'(m_ra) < DEPTH) ? m_mem[m_ra] : '0;
      arr_new = (we && (wa == m_ra)) ? merge(arr_old, di, wmask) : arr_old;
      if (ore) begin
        m_da  = byp_sel ? dbyp : arr_new;
        m_db  = byp_sel ? dbyp : arr_old;
        m_vld = m_re | byp_sel;
      end
      m_re = re;
      if (re) m_ra = ra;
      if (we && (int'(wa) < DEPTH)) m_mem[wa] = merge(m_mem[wa], di, wmask);
    end
    e.da = m_da; e.db = m_db; e.vld = m_vld; e.init = (m_clr >= DEPTH);
    exp_q.push_back(e);
  endtask

  // Model: sample inputs at each rising edge, push expected post-edge state.
  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Monitor: compare DUT outputs against the scoreboard on the falling edge.
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (!rstn) begin
      exp_q.delete();
      chk("rst_dout", 32'(dout_a), 32'd0);
      chk("rst_vld",  32'(vld_a),  32'd0);
      chk("rst_init", 32'(init_a), 32'd0);
      chk("rst_init_b", 32'(init_b), 32'd0);
    end else if (exp_q.size() == 0) begin
      chk("scoreboard_empty", 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      chk("dout_fwd",   32'(dout_a), 32'(e.da));
      chk("dout_nofwd", 32'(dout_b), 32'(e.db));
      chk("vld_fwd",    32'(vld_a),  32'(e.vld));
      chk("vld_nofwd",  32'(vld_b),  32'(e.vld));
      chk("init_fwd",   32'(init_a), 32'(e.init));
      chk("init_nofwd", 32'(init_b), 32'(e.init));
    end
  end

  task automatic cyc(input logic w, input logic [AW-1:0] a_w, input logic [MASK_W-1:0] m,
                     input logic [WIDTH-1:0] d, input logic r, input logic [AW-1:0] a_r,
                     input logic o, input logic b, input logic [WIDTH-1:0] db);
    we = w; wa = a_w; wmask = m; di = d; re = r; ra = a_r; ore = o; byp_sel = b; dbyp = db;
    pwr = $urandom;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    cyc(1'b0, '0, '0, '0, 1'b0, '0, 1'b0, 1'b0, '0);
  endtask

  task automatic rand_cyc(input logic ore_allowed);
    logic [AW-1:0] a_w, a_r;
    a_w = ($urandom_range(0, 1) == 0) ? 7'($urandom_range(0, 7))
        : (($urandom_range(0, 7) == 0) ? 7'($urandom_range(80, 127)) : 7'($urandom_range(0, 79)));
    a_r = ($urandom_range(0, 1) == 0) ? 7'($urandom_range(0, 7))
        : (($urandom_range(0, 7) == 0) ? 7'($urandom_range(80, 127)) : 7'($urandom_range(0, 79)));
    cyc(1'($urandom), a_w, 3'($urandom), 17'($urandom), 1'($urandom), a_r,
        ore_allowed & ($urandom_range(0, 3) != 0), ($urandom_range(0, 7) == 0), 17'($urandom));
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk); #1 rstn = 1'b1;

    // Clear running; abort at cycle 30 with a one-edge reset pulse.
    repeat (30) rand_cyc(1'b1);
    @(negedge clk); #1 rstn = 1'b0;
    @(negedge clk); #1 rstn = 1'b1;
    // Writes/reads during the restarted clear must be ignored.
    repeat (DEPTH + 5) rand_cyc(1'b1);
    idle();

    // Reads of 0, 40, 79 after clear, back-to-back.
    cyc(1'b0, '0, '0, '0, 1'b1, 7'd0,  1'b0, 1'b0, '0);
    cyc(1'b0, '0, '0, '0, 1'b1, 7'd40, 1'b1, 1'b0, '0);
    cyc(1'b0, '0, '0, '0, 1'b1, 7'd79, 1'b1, 1'b0, '0);
    cyc(1'b0, '0, '0, '0, 1'b0, '0,    1'b1, 1'b0, '0);
    idle();

    // Segment mask: 0x1FFFF full, then clear middle segment -> 0x1F03F.
    cyc(1'b1, 7'd5, 3'b111, 17'h1FFFF, 1'b0, '0, 1'b0, 1'b0, '0);
    cyc(1'b1, 7'd5, 3'b010, 17'h00000, 1'b0, '0, 1'b0, 1'b0, '0);
    cyc(1'b0, '0, '0, '0, 1'b1, 7'd5, 1'b0, 1'b0, '0);
    cyc(1'b0, '0, '0, '0, 1'b0, '0,   1'b1, 1'b0, '0);
    idle();

    // Forwarding: prior content 0x11111, same-cycle write of 0x0ABCD.
    cyc(1'b1, 7'd7, 3'b111, 17'h11111, 1'b0, '0, 1'b0, 1'b0, '0);
    cyc(1'b0, '0, '0, '0, 1'b1, 7'd7, 1'b0, 1'b0, '0);
    cyc(1'b1, 7'd7, 3'b111, 17'h0ABCD, 1'b0, '0, 1'b1, 1'b0, '0);
    idle();

    // Bypass with no pending read, then hold with ore low.
    cyc(1'b0, '0, '0, '0, 1'b0, '0, 1'b1, 1'b1, 17'h12345);
    repeat (4) rand_cyc(1'b0);
    idle();

    // Out of range write and read.
    cyc(1'b1, 7'd100, 3'b111, 17'h1DEAD, 1'b0, '0, 1'b0, 1'b0, '0);
    cyc(1'b0, '0, '0, '0, 1'b1, 7'd127, 1'b0, 1'b0, '0);
    cyc(1'b0, '0, '0, '0, 1'b1, 7'd20,  1'b1, 1'b0, '0);
    cyc(1'b0, '0, '0, '0, 1'b0, '0,     1'b1, 1'b0, '0);
    idle();

    // Randomised traffic with frequent address collisions.
    repeat (3000) rand_cyc(1'b1);
    idle();
    idle();
    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
